axis_burst_gen: RTL and testbench

//  Parametrised AXI4-Stream master traffic generator; successor to the fixed 8-word source.

---
 rtl/axis_burst_gen.sv | 156 +++++++++++++++
 tb/tb_axis_burst_gen.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/axis_burst_gen.sv
// axis_burst_gen -- AXI4-Stream master traffic generator.
//   After enable rises it waits C_M_START_COUNT cycles, then sends bursts of
//   C_BURST_LEN beats (TLAST on the final beat) with C_GAP_COUNT idle cycles
//   between them. It stops after C_NUM_BURSTS bursts (0 = never). TDATA is a
//   running count that starts at C_DATA_START and steps once per accepted beat.
// Ports:
//   M_AXIS_ACLK / M_AXIS_ARESETN  clock, async active-low reset
//   enable                        level; starts a session, low = stop at burst end
//   M_AXIS_T*                     AXI4-Stream master (TSTRB tied to all ones)
//   busy                          session active (INIT / SEND / GAP)
//   done                          burst quota reached; cleared once enable drops
//   burst_cnt                     bursts completed this session, saturating
// Build option:
//   AXIS_GEN_BURST_ID_EN  TDATA[W-1:W-8] carries burst_cnt[7:0]. The remaining
//                         low bits carry the data count.
module axis_burst_gen #(
  parameter int C_M_AXIS_TDATA_WIDTH = 32,
  parameter int C_M_START_COUNT      = 32,
  parameter int C_BURST_LEN          = 8,
  parameter int C_NUM_BURSTS         = 4,
  parameter int C_GAP_COUNT          = 2,
  parameter int C_DATA_START         = 1
) (
  input  logic                              M_AXIS_ACLK,
  input  logic                              M_AXIS_ARESETN,
  input  logic                              enable,
  output logic                              M_AXIS_TVALID,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0]   M_AXIS_TDATA,
  output logic [C_M_AXIS_TDATA_WIDTH/8-1:0] M_AXIS_TSTRB,
  output logic                              M_AXIS_TLAST,
  input  logic                              M_AXIS_TREADY,
  output logic                              busy,
  output logic                              done,
  output logic [15:0]                       burst_cnt
);
  localparam int W      = C_M_AXIS_TDATA_WIDTH;
  localparam int INIT_W = (C_M_START_COUNT > 1) ? $clog2(C_M_START_COUNT) : 1;
  localparam int BEAT_W = (C_BURST_LEN > 1)     ? $clog2(C_BURST_LEN)     : 1;
  localparam int GAP_W  = (C_GAP_COUNT > 1)     ? $clog2(C_GAP_COUNT)     : 1;
  localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(C_M_START_COUNT - 1);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(C_BURST_LEN - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((C_GAP_COUNT > 0) ? C_GAP_COUNT - 1 : 0);
  localparam logic [W-1:0]      DATA_INIT = W'(C_DATA_START);

  typedef enum logic [2:0] {S_IDLE, S_INIT, S_SEND, S_GAP, S_DONE} state_t;

  state_t              state, state_nx;
  logic [INIT_W-1:0]   init_cnt, init_nx;
  logic [BEAT_W-1:0]   beat_cnt, beat_nx;
  logic [GAP_W-1:0]    gap_cnt, gap_nx;
  logic [W-1:0]        data_cnt, data_nx;
  logic [15:0]         bcnt_q, bcnt_nx, bcnt_inc;
  logic                vld_nx, last_nx, busy_nx, done_nx;
  logic [W-1:0]        tdata_nx;

  assign M_AXIS_TSTRB = '1;
  assign burst_cnt    = bcnt_q;

  // State and counter registers
  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
    if (!M_AXIS_ARESETN) begin
      state    <= S_IDLE;
      init_cnt <= '0;
      beat_cnt <= '0;
      gap_cnt  <= '0;
      data_cnt <= '0;
      bcnt_q   <= '0;
    end else begin
      state    <= state_nx;
      init_cnt <= init_nx;
      beat_cnt <= beat_nx;
      gap_cnt  <= gap_nx;
      data_cnt <= data_nx;
      bcnt_q   <= bcnt_nx;
    end
  end

  // Next state and counters
  always_comb begin
    state_nx = state;
    init_nx  = init_cnt;
    beat_nx  = beat_cnt;
    gap_nx   = gap_cnt;
    data_nx  = data_cnt;
    bcnt_nx  = bcnt_q;
    bcnt_inc = (bcnt_q == 16'hFFFF) ? bcnt_q : bcnt_q + 16'd1;
    unique case (state)
      S_IDLE: if (enable) begin
        state_nx = S_INIT;
        init_nx  = '0;
        beat_nx  = '0;
        data_nx  = DATA_INIT;
        bcnt_nx  = '0;
      end
      S_INIT: begin
        if (!enable)                    state_nx = S_IDLE;
        else if (init_cnt == INIT_LAST) state_nx = S_SEND;
        else                            init_nx  = init_cnt + INIT_W'(1);
      end
      // TVALID is high throughout SEND, so TREADY alone marks acceptance.
      S_SEND: if (M_AXIS_TREADY) begin
        data_nx = data_cnt + W'(1);
        if (beat_cnt == BEAT_LAST) begin
          beat_nx = '0;
          bcnt_nx = bcnt_inc;
          if (C_NUM_BURSTS != 0 && bcnt_inc == 16'(C_NUM_BURSTS)) state_nx = S_DONE;
          else if (!enable)                                        state_nx = S_IDLE;
          else if (C_GAP_COUNT != 0) begin
            state_nx = S_GAP;
            gap_nx   = '0;
          end
          // otherwise stay in SEND: back-to-back bursts
        end else begin
          beat_nx = beat_cnt + BEAT_W'(1);
        end
      end
      S_GAP: begin
        if (gap_cnt == GAP_LAST) state_nx = enable ? S_SEND : S_IDLE;
        else                     gap_nx   = gap_cnt + GAP_W'(1);
      end
      S_DONE: if (!enable) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they leave a register with
  // no extra cycle of latency; while stalled all inputs hold, so they hold too.
  always_comb begin
    vld_nx  = (state_nx == S_SEND);
    last_nx = vld_nx && (beat_nx == BEAT_LAST);
    busy_nx = (state_nx == S_INIT) || (state_nx == S_SEND) || (state_nx == S_GAP);
    done_nx = (state_nx == S_DONE);
`ifdef AXIS_GEN_BURST_ID_EN
    tdata_nx = {bcnt_nx[7:0], data_nx[W-9:0]};
`else
    tdata_nx = data_nx;
`endif
  end

  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
    if (!M_AXIS_ARESETN) begin
      M_AXIS_TVALID <= 1'b0;
      M_AXIS_TLAST  <= 1'b0;
      M_AXIS_TDATA  <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      M_AXIS_TVALID <= vld_nx;
      M_AXIS_TLAST  <= last_nx;
      M_AXIS_TDATA  <= tdata_nx;
      busy          <= busy_nx;
      done          <= done_nx;
    end
  end

endmodule

// File: tb/tb_axis_burst_gen.sv
// Bench for axis_burst_gen. Instance a uses the default parameters. Instance b
// runs back-to-back and unlimited, with a start value just below the 32-bit wrap.
// Expected beats come from arithmetic on the session beat index n:
//   data = start + n
//   last = (n % 8 == 7)
//   burst id = n / 8
module tb_axis_burst_gen;
  localparam logic [31:0] A_BASE = 32'd1;
  localparam logic [31:0] B_BASE = 32'hFFFF_FFF0;

  logic clk = 1'b0, rst_n = 1'b0;
  logic en_a = 1'b0, rdy_a = 1'b0, en_b = 1'b0, rdy_b = 1'b1;
  logic vld_a, last_a, busy_a, done_a, vld_b, last_b, busy_b, done_b;
  logic [31:0] data_a, data_b;
  logic [3:0]  strb_a, strb_b;
  logic [15:0] bcnt_a, bcnt_b;

  always #5 clk = ~clk;

  axis_burst_gen u_a (
    .M_AXIS_ACLK(clk), .M_AXIS_ARESETN(rst_n), .enable(en_a),
    .M_AXIS_TVALID(vld_a), .M_AXIS_TDATA(data_a), .M_AXIS_TSTRB(strb_a),
    .M_AXIS_TLAST(last_a), .M_AXIS_TREADY(rdy_a),
    .busy(busy_a), .done(done_a), .burst_cnt(bcnt_a));

  axis_burst_gen #(
    .C_M_START_COUNT(4), .C_NUM_BURSTS(0), .C_GAP_COUNT(0),
    .C_DATA_START(-16)   // 0xFFFF_FFF0
  ) u_b (
    .M_AXIS_ACLK(clk), .M_AXIS_ARESETN(rst_n), .enable(en_b),
    .M_AXIS_TVALID(vld_b), .M_AXIS_TDATA(data_b), .M_AXIS_TSTRB(strb_b),
    .M_AXIS_TLAST(last_b), .M_AXIS_TREADY(rdy_b),
    .busy(busy_b), .done(done_b), .burst_cnt(bcnt_b));

  int n_cmp = 0, n_err = 0, cycle = 0;
  int beat_a = 0, gap_run = 0, rdy_mode = 0, hold_lo = 0;
  bit in_gap = 0, stalled = 0;
  logic [31:0] prev_data = '0, acc_data = '0;
  logic        prev_last = 1'b0;
  bit b_on = 0, b_seen = 0;
  int nb = 0, bcyc = 0, b_first = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cycle);
    end
  endtask

  function automatic logic [31:0] exp_data(input logic [31:0] base, input int n);
    logic [31:0] d;
    d = base + 32'(n);
`ifdef AXIS_GEN_BURST_ID_EN
    d[31:24] = 8'(n / 8);
`endif
    return d;
  endfunction

  task automatic new_session();
    beat_a = 0; in_gap = 0; gap_run = 0; stalled = 0; hold_lo = 0;
  endtask

  // One clock: sample at the falling edge, then drive TREADY for the next rise.
  task automatic cyc();
    @(negedge clk);
    cycle++;
    if (stalled) begin
      chk("stall_vld", vld_a, 1'b1);
      chk("stall_data", data_a, prev_data);
      chk("stall_last", last_a, prev_last);
    end
    if (vld_a) begin
      if (in_gap) chk("gap_len", gap_run, 2);
      in_gap = 0;
    end else if (in_gap) gap_run++;
    if (hold_lo > 0) begin
      rdy_a = 1'b0;
      hold_lo--;
    end else begin
      case (rdy_mode)
        0:       rdy_a = 1'b1;
        1:       rdy_a = 1'($urandom_range(0, 1));
        default: rdy_a = (cycle % 2 == 0);
      endcase
    end
    if (vld_a && rdy_a) begin
      chk("data", data_a, exp_data(A_BASE, beat_a));
      chk("last", last_a, (beat_a % 8) == 7);
      chk("bcnt", bcnt_a, beat_a / 8);
      acc_data = data_a;
      if ((beat_a % 8) == 7 && beat_a != 31) begin in_gap = 1; gap_run = 0; end
      beat_a++;
    end
    stalled   = vld_a && !rdy_a;
    prev_data = data_a;
    prev_last = last_a;
    if (b_on) begin
      bcyc++;
      if (b_seen) chk("b_vld_hold", vld_b, 1'b1);
      if (vld_b) begin
        if (!b_seen) b_first = bcyc;
        b_seen = 1;
        chk("b_data", data_b, exp_data(B_BASE, nb));
        chk("b_last", last_b, (nb % 8) == 7);
        chk("b_bcnt", bcnt_b, nb / 8);
        if (nb == 16) chk("b_wrap", data_b[23:0], 24'h0);
        nb++;
      end
    end
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (!done_a && k < budget) begin cyc(); k++; end
    chk("done_timeout", done_a, 1'b1);
  endtask

  task automatic wait_beat(input int n, input int budget);
    int k = 0;
    while (beat_a < n && k < budget) begin cyc(); k++; end
    chk("beat_timeout", beat_a >= n, 1'b1);
  endtask

  task automatic end_session();
    en_a = 1'b0;
    cyc(); cyc();
    chk("idle_done", done_a, 1'b0);
    chk("idle_busy", busy_a, 1'b0);
  endtask

  initial begin
    int first, k;
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_vld", vld_a, 1'b0);
    chk("rst_data", data_a, 32'h0);
    chk("rst_last", last_a, 1'b0);
    chk("rst_strb", strb_a, 4'hF);
    chk("rst_busy", busy_a, 1'b0);
    chk("rst_done", done_a, 1'b0);
    chk("rst_bcnt", bcnt_a, 16'h0);
    chk("rst_strb_b", strb_b, 4'hF);

    // Defaults, TREADY=1, enable from reset release
    new_session(); rdy_mode = 0; en_a = 1'b1; rst_n = 1'b1;
    first = 0;
    for (int i = 1; i <= 100; i++) begin
      cyc();
      if (i == 1) chk("busy_init", busy_a, 1'b1);
      if (vld_a) begin first = i; break; end
    end
    chk("first_vld", first, 33);
    wait_done(400);
    chk("t1_beats", beat_a, 32);
    chk("t1_bcnt", bcnt_a, 16'd4);
    chk("t1_busy", busy_a, 1'b0);
    cyc();
    chk("t1_quiet", vld_a, 1'b0);
    end_session();

    // TREADY 1010, then held low 5 cycles mid-burst, then random
    new_session(); rdy_mode = 2; en_a = 1'b1;
    wait_beat($urandom_range(9, 14), 400);
    hold_lo = 5; rdy_mode = 1;
    wait_done(800);
    chk("t2_beats", beat_a, 32);
    chk("t2_bcnt", bcnt_a, 16'd4);
    end_session();

    // enable dropped during burst 2
    new_session(); rdy_mode = 1; en_a = 1'b1;
    wait_beat($urandom_range(9, 14), 600);
    en_a = 1'b0;
    k = 0;
    while (busy_a && k < 300) begin cyc(); k++; end
    chk("t4_busy", busy_a, 1'b0);
    chk("t4_beats", beat_a, 16);
    chk("t4_bcnt", bcnt_a, 16'd2);
    chk("t4_done", done_a, 1'b0);
    repeat (20) cyc();
    chk("t4_no_more", beat_a, 16);

    // Asynchronous reset in burst 1
    new_session(); rdy_mode = 1; en_a = 1'b1;
    wait_beat($urandom_range(1, 7), 400);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_vld", vld_a, 1'b0);
    chk("arst_last", last_a, 1'b0);
    chk("arst_data", data_a, 32'h0);
    chk("arst_bcnt", bcnt_a, 16'h0);
    new_session();
    cyc(); cyc();
    rst_n = 1'b1;
    wait_beat(1, 200);
    chk("t5_restart", acc_data, exp_data(A_BASE, 0));
    wait_done(800);
    chk("t5_beats", beat_a, 32);
    end_session();

    // Instance b: back-to-back, unlimited, wrapping
    en_b = 1'b1; b_on = 1;
    repeat (45) cyc();
    chk("b_first", b_first, 5);
    chk("b_beats", nb, 41);
    chk("b_busy", busy_b, 1'b1);
    chk("b_done", done_b, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end
endmodule
